// File: rtl/icache_refill.sv
// Refill engine for the instruction cache. Each miss issues one 16-beat AXI4 INCR
// burst, and every returned beat is written into the data array as a masked 32-bit lane.
module icache_refill #(
  parameter int         IDX_LEN = 7,
  parameter int         BLK_LEN = 6,
  parameter logic [3:0] AXI_ID  = 4'd0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               miss_req_i,
  input  logic [31:0]        miss_addr_i,
  output logic               miss_ready_o,
  output logic               refill_done_o,
  output logic               refill_err_o,
  output logic [3:0]         axi_arid_o,
  output logic [31:0]        axi_araddr_o,
  output logic [7:0]         axi_arlen_o,
  output logic [2:0]         axi_arsize_o,
  output logic [1:0]         axi_arburst_o,
  output logic               axi_arvalid_o,
  input  logic               axi_arready_i,
  input  logic [31:0]        axi_rdata_i,
  input  logic [1:0]         axi_rresp_i,
  input  logic               axi_rlast_i,
  input  logic               axi_rvalid_i,
  output logic               axi_rready_o,
  output logic [IDX_LEN-1:0] icache_index_o,
  output logic [3:0]         icache_burst_count_o,
  output logic [127:0]       icache_line_wdata_o,
  output logic [127:0]       icache_wmask_o,
  output logic               icache_wen_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [31-BLK_LEN:0] r_line;
  logic [3:0]          r_cnt;
  logic                r_err;
  logic                r_miss_ready;
  logic                r_arvalid;
  logic                r_rready;
  logic                r_done;
  logic                r_done_err;

  logic w_wen;
  logic w_cnt_max;
  logic w_last_beat;
  logic w_beat_err;
  logic w_unused_offset;

  // rready is only ever high in the data phase, so it doubles as the phase qualifier.
  assign w_wen       = r_rready & axi_rvalid_i;
  assign w_cnt_max   = (r_cnt == 4'hF);
  assign w_last_beat = axi_rlast_i | w_cnt_max;
  // An rlast that disagrees with the beat count flags both early and missing last.
  assign w_beat_err  = (axi_rresp_i != 2'b00) | (axi_rlast_i ^ w_cnt_max);

  assign w_unused_offset = ^miss_addr_i[BLK_LEN-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_line       <= '0;
      r_cnt        <= 4'd0;
      r_err        <= 1'b0;
      r_miss_ready <= 1'b1;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_done       <= 1'b0;
      r_done_err   <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_done_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (miss_req_i) begin
            r_line       <= miss_addr_i[31:BLK_LEN];
            r_cnt        <= 4'd0;
            r_err        <= 1'b0;
            r_miss_ready <= 1'b0;
            r_arvalid    <= 1'b1;
            r_state      <= S_AR;
          end
        end
        S_AR: begin
          if (axi_arready_i) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_R;
          end
        end
        S_R: begin
          if (axi_rvalid_i) begin
            r_err <= r_err | w_beat_err;
            if (w_last_beat) begin
              r_rready   <= 1'b0;
              r_done     <= 1'b1;
              r_done_err <= r_err | w_beat_err;
              r_state    <= S_DONE;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
        end
        S_DONE: begin
          r_miss_ready <= 1'b1;
          r_state      <= S_IDLE;
        end
        default: begin
          r_miss_ready <= 1'b1;
          r_arvalid    <= 1'b0;
          r_rready     <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

  assign miss_ready_o         = r_miss_ready;
  assign refill_done_o        = r_done;
  assign refill_err_o         = r_done_err;
  assign axi_arid_o           = AXI_ID;
  assign axi_araddr_o         = {r_line, {BLK_LEN{1'b0}}};
  assign axi_arlen_o          = 8'd15;
  assign axi_arsize_o         = 3'b010;
  assign axi_arburst_o        = 2'b01;
  assign axi_arvalid_o        = r_arvalid;
  assign axi_rready_o         = r_rready;
  assign icache_index_o       = r_line[IDX_LEN-1:0];
  assign icache_burst_count_o = r_cnt;
  assign icache_wen_o         = w_wen;

  // Lane select uses the low two count bits; the bank is carried by burst_count[3:2].
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign icache_line_wdata_o[gi*32 +: 32] = w_wen ? axi_rdata_i : 32'd0;
      assign icache_wmask_o[gi*32 +: 32]      = {32{w_wen && (r_cnt[1:0] == 2'(gi))}};
    end
  endgenerate

endmodule

// File: doc/icache_refill.md
Name: icache_refill

Overview:
- Miss-side refill engine that fills the instruction-cache data array.
- On a miss it issues one AXI4 INCR read burst for the 64-byte line: 16 beats of 32 bits each.
- Each returned beat is steered into the data array as a masked 32-bit write within a 128-bit bank word. The write carries an index, a 4-bit burst count (bits [3:2] select the bank, bits [1:0] select the lane), the write data, a mask and a write enable.
- Signals completion or error to the icache controller.

Parameters:
IDX_LEN, 7, set-index width (miss_addr_i[BLK_LEN+IDX_LEN-1:BLK_LEN])
BLK_LEN, 6, in-line byte-offset width (64-byte line)
AXI_ID, 0, constant value driven on axi_arid_o

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-low
miss_req_i  input  1  refill request, sampled only when miss_ready_o=1
miss_addr_i  input  32  miss address (any byte within line)
miss_ready_o  output  1  engine idle, can accept a request
refill_done_o  output  1  one-cycle pulse: line complete
refill_err_o  output  1  valid with refill_done_o: bad response or beat-count mismatch
axi_arid_o  output  4  =AXI_ID
axi_araddr_o  output  32  line-aligned address {addr[31:6],6'b0}
axi_arlen_o  output  8  constant 15
axi_arsize_o  output  3  constant 3'b010
axi_arburst_o  output  2  constant 2'b01 (INCR)
axi_arvalid_o  output  1  address valid
axi_arready_i  input  1  address ready
axi_rdata_i  input  32  read data
axi_rresp_i  input  2  read response
axi_rlast_i  input  1  last beat
axi_rvalid_i  input  1  data valid
axi_rready_o  output  1  data ready
icache_index_o  output  IDX_LEN  latched set index
icache_burst_count_o  output  4  beat counter
icache_line_wdata_o  output  128  {4{axi_rdata_i}}
icache_wmask_o  output  128  32 ones at lane burst_count[1:0]*32, zeros elsewhere
icache_wen_o  output  1  data-array write strobe

Behaviour:
- Reset (rst=0, asynchronous):
  - State=IDLE; beat counter=0; sticky error flag=0; latched address=0.
  - All outputs are 0 except miss_ready_o=1 and the AR constants.
- State IDLE:
  - miss_ready_o=1.
  - On miss_req_i=1: latch the address, clear counter and error flag, go to AR next cycle.
- State AR:
  - axi_arvalid_o=1, address stable.
  - Hold until axi_arready_i=1; the handshake cycle transitions to R.
  - arvalid is never withdrawn before the handshake.
- State R:
  - axi_rready_o=1.
  - A beat is accepted on a cycle with axi_rvalid_i=1. In that same cycle (combinational from rvalid):
    - icache_wen_o=1
    - burst_count_o=counter
    - wmask lane = counter[1:0]
    - wdata replicated
  - icache_wen_o=0 on any cycle without rvalid. Gaps in rvalid are tolerated.
  - Counter increments after each beat (4-bit, no wrap beyond 15).
  - axi_rresp_i != 2'b00 on any beat sets the sticky error. The beat is still written.
  - Exit to DONE after the beat where rlast=1 or counter==15, whichever comes first.
  - rlast with counter != 15 sets error (early last).
  - counter==15 without rlast sets error (missing last).
- State DONE (1 cycle):
  - refill_done_o=1; refill_err_o=sticky error.
  - Go to IDLE; miss_ready_o=1 again the following cycle.
- Latency, no stalls: request to arvalid is 1 cycle; arready to first accepted beat is ≥1 cycle; the last beat is followed by the done pulse on the next cycle.
- icache_index_o holds the latched index from AR through DONE.
- Request handling: miss_req_i outside IDLE is ignored. No queuing; the requester holds its request.
- Reset mid-burst: return to IDLE immediately with no further writes; rready=0. Draining stale beats is the interconnect's responsibility (it shares the reset).
- Sub-line offset bits of miss_addr_i are ignored. Refill always starts at beat 0 (no critical-word-first).

Test Plan:
- Basic refill:
  - Stimulus: miss_addr_i=0x8000_1234, arready=1, 16 back-to-back beats with rdata=beat index.
  - Required: araddr=0x8000_1200, index=0x48. Writes with burst_count 0..15; beat 5 has wmask=0x..._FFFFFFFF<<32 in bank 1. Done pulse one cycle after beat 15, err=0.
- Handshake stalls:
  - Stimulus: arready delayed 3 cycles; rvalid toggled 1,0,0,1.
  - Required: arvalid and araddr stable for 4 cycles. Exactly 16 wen pulses, none while rvalid=0.
- Error response:
  - Stimulus: rresp=2'b10 on beat 7.
  - Required: all 16 beats written; done with err=1.
- Beat-count mismatches:
  - Stimulus: rlast asserted on beat 9.
  - Required: done after beat 9 with err=1; 10 writes total.
  - Stimulus: no rlast on beat 15.
  - Required: done with err=1.
- Reset mid-burst:
  - Stimulus: rst low after beat 4.
  - Required: wen=0, rready=0, miss_ready_o=1 immediately. A new request afterwards starts at burst_count 0.
- Back-to-back requests:
  - Stimulus: two requests back-to-back; miss_req_i held high during the first refill.
  - Required: second AR issues only after the done pulse, 1 cycle after IDLE re-entry.
